// File: rtl/router_pkg.sv
// Shared types and default sizing for the layer sequencer and its helpers.
package router_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_ROW_COUNT  = 4;
  localparam int DEF_CTX_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CONFIG     = 3'd1,
    LOAD       = 3'd2,
    WAIT_READY = 3'd3,
    STREAM     = 3'd4,
    DONE       = 3'd5
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
// Count is visible the cycle after the increment; no backpressure.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/router_sequencer.sv
// Layer scheduler: latches config, starts input/weight routers, pops both in lockstep and counts contexts.
// Pop strobe is combinational from the ready inputs; systolic-array backpressure only stalls and is counted.
module router_sequencer
  import router_pkg::*;
#(
  parameter int ROW_COUNT  = DEF_ROW_COUNT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CTX_WIDTH  = DEF_CTX_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_reg_clear,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_o_size,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  output logic                  o_ir_en,
  output logic [ADDR_WIDTH-1:0] o_ir_start_addr,
  output logic [ADDR_WIDTH-1:0] o_ir_o_size,
  output logic [ADDR_WIDTH-1:0] o_ir_stride,
  output logic                  o_ir_reg_clear,
  input  logic                  i_ir_ready,
  input  logic                  i_ir_context_done,
  input  logic                  i_ir_done,
  output logic                  o_wr_en,
  output logic                  o_wr_reuse,
  input  logic                  i_wr_ready,
  input  logic                  i_sa_ready,
  output logic                  o_pop_en,
  output logic [CTX_WIDTH-1:0]  o_ctx_count,
  output logic [CTX_WIDTH-1:0]  o_stall_cycles,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2:0]            o_state
);

  localparam int PW = 2 * ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, o_size_q, stride_q;
  logic [CTX_WIDTH-1:0]  expected_q, expected_d;
  logic                  done_q, err_q, reuse_q, reuse_d;
  logic                  start_fire, cnt_clr, ctx_inc, stall_inc, routers_rdy, ctx_mismatch;
  logic [PW-1:0]         area_rounded;

  assign start_fire   = (state_q == IDLE) && i_start;
  assign cnt_clr      = i_reg_clear || start_fire;
  assign routers_rdy  = i_ir_ready && i_wr_ready;
  assign ctx_mismatch = (o_ctx_count != expected_q);

  // Contexts needed = ceil(size^2 / ROW_COUNT); widened so the rounding add cannot wrap.
  assign area_rounded = PW'(i_o_size) * PW'(i_o_size) + PW'(ROW_COUNT - 1);
  assign expected_d   = CTX_WIDTH'(area_rounded / PW'(ROW_COUNT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else if (i_reg_clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctx_inc = 1'b0;
    reuse_d = 1'b0;
    case (state_q)
      IDLE:   if (i_start) state_d = CONFIG;
      CONFIG: state_d = (o_size_q == '0) ? DONE : LOAD;
      LOAD:   state_d = WAIT_READY;
      WAIT_READY, STREAM: begin
        // Final coordinate closes the open context; a simultaneous context_done is the same event.
        if (i_ir_done) begin
          ctx_inc = 1'b1;
          state_d = DONE;
        end else if (i_ir_context_done) begin
          ctx_inc = 1'b1;
          reuse_d = 1'b1;
          state_d = WAIT_READY;
        end else if ((state_q == WAIT_READY) && routers_rdy) begin
          state_d = STREAM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (state_q != IDLE);
    o_ir_reg_clear = (state_q == CONFIG);
    o_ir_en        = (state_q == LOAD) || (state_q == WAIT_READY) || (state_q == STREAM);
    o_wr_en        = o_ir_en;
    o_pop_en       = (state_q == STREAM) && routers_rdy && i_sa_ready;
    stall_inc      = (state_q == STREAM) && routers_rdy && !i_sa_ready;
    o_done         = done_q || (state_q == DONE);
    o_err          = err_q || ((state_q == DONE) && ctx_mismatch);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_addr_q <= '0;
      o_size_q     <= '0;
      stride_q     <= '0;
      expected_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      reuse_q      <= 1'b0;
    end else if (i_reg_clear) begin
      start_addr_q <= '0;
      o_size_q     <= '0;
      stride_q     <= '0;
      expected_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      reuse_q      <= 1'b0;
    end else begin
      reuse_q <= reuse_d;
      if (start_fire) begin
        start_addr_q <= i_start_addr;
        o_size_q     <= i_o_size;
        stride_q     <= i_stride;
        expected_q   <= expected_d;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
      end
      if (state_q == DONE) begin
        done_q <= 1'b1;
        err_q  <= ctx_mismatch;
      end
    end
  end

  sat_counter #(.WIDTH(CTX_WIDTH)) u_ctx_cnt (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (cnt_clr),
    .inc_i   (ctx_inc),
    .count_o (o_ctx_count)
  );

  sat_counter #(.WIDTH(CTX_WIDTH)) u_stall_cnt (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (cnt_clr),
    .inc_i   (stall_inc),
    .count_o (o_stall_cycles)
  );

  assign o_wr_reuse      = reuse_q;
  assign o_ir_start_addr = start_addr_q;
  assign o_ir_o_size     = o_size_q;
  assign o_ir_stride     = stride_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_router_sequencer.sv
// Bench for router_sequencer: table of layers checked through a result queue, plus stall/reset/zero-size corners.
module tb_router_sequencer;
  import router_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_reg_clear = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_start_addr = '0, i_o_size = '0, i_stride = '0;
  logic        i_ir_ready = 1'b0, i_ir_context_done = 1'b0, i_ir_done = 1'b0;
  logic        i_wr_ready = 1'b0, i_sa_ready = 1'b0;
  logic        o_ir_en, o_ir_reg_clear, o_wr_en, o_wr_reuse, o_pop_en, o_busy, o_done, o_err;
  logic [7:0]  o_ir_start_addr, o_ir_o_size, o_ir_stride;
  logic [15:0] o_ctx_count, o_stall_cycles;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;
  int reuse_cnt = 0;
  int ir_en_cnt = 0;

  typedef struct {
    logic [7:0]  size;
    int          n_ctx;
    logic        both;
    logic [15:0] exp_ctx;
    logic        exp_err;
    int          exp_reuse;
  } vec_t;

  typedef struct {
    logic [15:0] ctx;
    logic        err;
    int          reuse;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];

  router_sequencer dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_reg_clear       (i_reg_clear),
    .i_start           (i_start),
    .i_start_addr      (i_start_addr),
    .i_o_size          (i_o_size),
    .i_stride          (i_stride),
    .o_ir_en           (o_ir_en),
    .o_ir_start_addr   (o_ir_start_addr),
    .o_ir_o_size       (o_ir_o_size),
    .o_ir_stride       (o_ir_stride),
    .o_ir_reg_clear    (o_ir_reg_clear),
    .i_ir_ready        (i_ir_ready),
    .i_ir_context_done (i_ir_context_done),
    .i_ir_done         (i_ir_done),
    .o_wr_en           (o_wr_en),
    .o_wr_reuse        (o_wr_reuse),
    .i_wr_ready        (i_wr_ready),
    .i_sa_ready        (i_sa_ready),
    .o_pop_en          (o_pop_en),
    .o_ctx_count       (o_ctx_count),
    .o_stall_cycles    (o_stall_cycles),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_state           (o_state)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wr_reuse) reuse_cnt = reuse_cnt + 1;
    if (o_ir_en)    ir_en_cnt = ir_en_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input string nm);
    int n = 0;
    while (o_state !== st && n < 50) begin
      tick();
      n++;
    end
    check(nm, 32'(o_state), 32'(st));
  endtask

  task automatic run_layer(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    int   reuse_base;
    e.ctx = v.exp_ctx;
    e.err = v.exp_err;
    e.reuse = v.exp_reuse;
    sb.push_back(e);
    reuse_base = reuse_cnt;
    i_start_addr = 8'(idx * 16 + 3);
    i_o_size = v.size;
    i_stride = 8'd1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("cfg_state", 32'(o_state), 32'(CONFIG));
    check("cfg_clear", 32'(o_ir_reg_clear), 32'd1);
    check("cfg_done_cleared", 32'(o_done), 32'd0);
    tick();
    check("load_en", 32'({o_ir_en, o_wr_en, o_ir_reg_clear}), 32'b110);
    check("load_addr", 32'(o_ir_start_addr), 32'(idx * 16 + 3));
    for (int c = 0; c < v.n_ctx; c++) begin
      wait_state(STREAM, "ctx_stream");
      i_ir_context_done = 1'b1;
      tick();
      i_ir_context_done = 1'b0;
    end
    wait_state(STREAM, "final_stream");
    i_ir_done = 1'b1;
    i_ir_context_done = v.both;
    tick();
    i_ir_done = 1'b0;
    i_ir_context_done = 1'b0;
    check("done_state", 32'(o_state), 32'(DONE));
    check("done_flag", 32'(o_done), 32'd1);
    check("done_err", 32'(o_err), 32'(v.exp_err));
    check("done_en_drop", 32'({o_ir_en, o_wr_en}), 32'd0);
    tick();
    check("idle_after_done", 32'(o_state), 32'(IDLE));
    check("done_sticky", 32'({o_done, o_busy}), 32'b10);
    got = sb.pop_front();
    check("sb_ctx_count", 32'(o_ctx_count), 32'(got.ctx));
    check("sb_err", 32'(o_err), 32'(got.err));
    check("sb_reuse_pulses", 32'(reuse_cnt - reuse_base), 32'(got.reuse));
  endtask

  initial begin
    int base;
    vecs[0] = '{8'd4,  3,  1'b0, 16'd4,  1'b0, 3};
    vecs[1] = '{8'd4,  1,  1'b0, 16'd2,  1'b1, 1};
    vecs[2] = '{8'd3,  2,  1'b0, 16'd3,  1'b0, 2};
    vecs[3] = '{8'd5,  6,  1'b0, 16'd7,  1'b0, 6};
    vecs[4] = '{8'd2,  0,  1'b0, 16'd1,  1'b0, 0};
    vecs[5] = '{8'd4,  3,  1'b1, 16'd4,  1'b0, 3};
    vecs[6] = '{8'd4,  2,  1'b1, 16'd3,  1'b1, 2};
    vecs[7] = '{8'd16, 63, 1'b0, 16'd64, 1'b0, 63};
    vecs[8] = '{8'd1,  0,  1'b0, 16'd1,  1'b0, 0};
    vecs[9] = '{8'd6,  7,  1'b1, 16'd8,  1'b1, 7};

    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    check("rst_state", 32'(o_state), 32'(IDLE));
    check("rst_flags", 32'({o_busy, o_done, o_err, o_ir_en, o_wr_en, o_pop_en, o_wr_reuse, o_ir_reg_clear}), 32'd0);
    check("rst_counts", 32'({o_ctx_count, o_stall_cycles}), 32'd0);
    check("rst_cfg", 32'({o_ir_start_addr, o_ir_o_size, o_ir_stride}), 32'd0);

    i_ir_ready = 1'b1;
    i_wr_ready = 1'b1;
    i_sa_ready = 1'b1;
    foreach (vecs[i]) run_layer(vecs[i], i);

    // Stall counting, ignored mid-layer start, then async reset inside STREAM.
    i_start_addr = 8'h11; i_o_size = 8'd4; i_stride = 8'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_state(STREAM, "stall_stream");
    i_start_addr = 8'h99; i_o_size = 8'd0; i_stride = 8'd7; i_start = 1'b1;
    i_sa_ready = 1'b0;
    #1;
    check("stall_pop_low", 32'(o_pop_en), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      i_start = 1'b0;
      check("stall_pop_hold", 32'(o_pop_en), 32'd0);
    end
    check("stall_cycles", 32'(o_stall_cycles), 32'd5);
    check("midstart_state", 32'(o_state), 32'(STREAM));
    check("midstart_cfg", 32'({o_ir_start_addr, o_ir_o_size, o_ir_stride}), 32'h110402);
    i_sa_ready = 1'b1;
    #1;
    check("pop_resume", 32'(o_pop_en), 32'd1);
    i_rst = 1'b1;
    #1;
    check("rst_async_drop", 32'({o_ir_en, o_wr_en, o_pop_en, o_busy}), 32'd0);
    tick();
    check("rst_mid_state", 32'(o_state), 32'(IDLE));
    check("rst_mid_nodone", 32'({o_done, o_err}), 32'd0);
    i_rst = 1'b0;
    tick();

    // Zero-size layer goes straight from CONFIG to DONE.
    base = ir_en_cnt;
    i_o_size = 8'd0; i_start_addr = 8'h42; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("zero_config", 32'(o_state), 32'(CONFIG));
    tick();
    check("zero_done", 32'({o_done, o_err}), 32'b10);
    check("zero_ctx", 32'(o_ctx_count), 32'd0);
    tick();
    check("zero_idle", 32'(o_state), 32'(IDLE));
    check("zero_no_enable", 32'(ir_en_cnt - base), 32'd0);

    // Synchronous clear after an erroring layer wipes flags and config.
    run_layer(vecs[1], 5);
    i_reg_clear = 1'b1;
    tick();
    i_reg_clear = 1'b0;
    check("clear_flags", 32'({o_done, o_err, o_busy}), 32'd0);
    check("clear_cfg", 32'({o_ir_start_addr, o_ctx_count}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
